jtag_tap_master: RTL
====================

// Module: jtag_tap_master
// PURPOSE
// - Host-side JTAG initiator. Turns {op,len,data} commands into IEEE 1149.1 TCK/TMS/TDI sequences and returns TDO bits.
// - Drives the tap_controller pins of a DUT TAP from the on-chip debug/test sequencer.
// - Keeps a shadow copy of the target TAP state so every scan enters from and returns to RUN_TEST_IDLE.
// PARAMETERS
// - CLK_DIV  4   clk_i cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV clk_i.
// - MAX_LEN  32  maximum scan length in bits; LEN_W = $clog2(MAX_LEN+1) is a derived localparam.
// PORTS
// - clk_i        in   1        system clock
// - trst_i       in   1        reset, asynchronous, active-low
// - cmd_valid_i  in   1        command valid
// - cmd_ready_o  out  1        command ready
// - cmd_op_i     in   2        tap_op_t: OP_RESET=0, OP_SCAN_IR=1, OP_SCAN_DR=2, OP_RUNTEST=3
// - cmd_len_i    in   LEN_W    scan bits / RUNTEST cycles; range 1..MAX_LEN
// - cmd_data_i   in   MAX_LEN  TDI payload, shifted LSB first
// - rsp_valid_o  out  1        response valid
// - rsp_ready_i  in   1        response ready
// - rsp_data_o   out  MAX_LEN  captured TDO bits, LSB = first bit shifted; unused MSBs are 0
// - rsp_err_o    out  1        illegal command: len==0 or len>MAX_LEN on a scan/RUNTEST op
// - tck_o        out  1        JTAG clock; idles low
// - tms_o        out  1        JTAG mode select
// - tdi_o        out  1        JTAG data to target
// - tdo_i        in   1        JTAG data from target
// - trst_n_o     out  1        target TAP reset, active-low; see CONFIGURATION
// - tap_state_o  out  4        shadow target state (tap_state_t)
// BEHAVIOUR
// - Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, trst_n_o=1, tap_state_o=TEST_LOGIC_RESET.
// - Only one command is outstanding at a time.
//   - A command is accepted on valid&&ready. cmd_ready_o drops on the next clk.
//   - cmd_ready_o returns 1 on the clk after rsp_valid_o&&rsp_ready_i.
//   - rsp_* stays stable while rsp_valid_o=1 and rsp_ready_i=0.
// - TCK bit timing:
//   - tms_o/tdi_o update at the start of each TCK low phase.
//   - tck_o rises CLK_DIV clk later.
//   - tdo_i is registered on the clk edge that drives tck_o high.
//   - Shadow state advances on that same edge, using the standard 16-state TAP transition table.
// - FSM states: IDLE -> PREAMBLE -> NAV_IN -> SHIFT -> NAV_OUT -> RESP; OP_RESET and OP_RUNTEST go PREAMBLE -> RESP.
//   - PREAMBLE: if shadow==TEST_LOGIC_RESET and op!=OP_RESET, emit one TMS=0 (-> RUN_TEST_IDLE).
//   - OP_RESET: 5 TCK with TMS=1, then 1 TCK with TMS=0. Ends in RUN_TEST_IDLE, rsp_data_o=0.
//   - OP_SCAN_DR TMS sequence: 1,0,0 | len bits (TMS=0 except the last bit, TMS=1) | 1,0. That is len+5 TCK.
//   - OP_SCAN_IR TMS sequence: 1,1,0,0 | len bits | 1,0. That is len+6 TCK.
//   - OP_RUNTEST: len TCK with TMS=0 and TDI=0.
//   - TDI during navigation cycles is 0.
// - Latency: rsp_valid_o rises 1 clk after the final TCK falling edge. Total = N_tck*2*CLK_DIV+1 clk from acceptance.
// - Error case (len==0 or len>MAX_LEN on a scan/RUNTEST op):
//   - Command is accepted; no TCK is generated.
//   - Response has rsp_err_o=1 and rsp_data_o=0; shadow state is unchanged.
//   - OP_RESET ignores len.
// - Mid-operation reset: trst_i low immediately forces all reset values. The in-flight command is dropped and produces no response.
// - tck_o never glitches and has no partial periods. The TCK high phase is always exactly CLK_DIV clk.
// CONFIGURATION
// - Macro JTAG_MASTER_TRST_EN.
// - Defined: OP_RESET first drives trst_n_o=0 for 2 TCK periods with tck_o held low, then runs the 5+1 TMS sequence.
// - Undefined: trst_n_o is tied to 1, and OP_RESET uses the TMS sequence only.
// STRUCTURE
// - tap_pkg holds:
//   - tap_state_t (16-state enum, shared with tap_controller)
//   - tap_op_t
//   - a function tap_next_state(state, tms)
//   - the constant TAP_RESET_TMS_CYCLES=5
// - Sub-module jtag_tck_gen (CLK_DIV counter) provides:
//   - tck_o
//   - one-clk rise_pulse / fall_pulse strobes
//   - enable input start_i and stop-at-low behaviour
// - The top-level module holds the command FSM, bit counter, TDI/TDO shift registers and shadow state.
// TESTING
// - Bench: tap_controller plus a behavioural IR(5b, capture 5'b00001) and DR(IDCODE 32'h1BAD_C0DE) target.
// - Release from reset, OP_RESET -> 6 TCK, TMS=1,1,1,1,1,0; tap_state_o=RUN_TEST_IDLE; rsp_data_o=0.
// - Reset IR/DR scans:
//   - OP_SCAN_IR, len=5, data=5'h1E -> 11 TCK; rsp_data_o=5'h01; target IR=5'h1E.
//   - Then OP_SCAN_DR, len=32, data=0 -> 37 TCK; rsp_data_o=32'h1BAD_C0DE.
// - OP_RUNTEST, len=10 -> exactly 10 tck_o rises with TMS=0; shadow stays in RUN_TEST_IDLE.
// - len=0 on OP_SCAN_DR -> rsp_err_o=1 with zero tck_o edges. Hold rsp_ready_i=0 for 20 clk -> rsp stable, cmd_ready_o=0.
// - Assert trst_i during bit 7 of a 32-bit DR scan -> outputs at reset values in the same cycle; no rsp_valid_o; next OP_RESET works.
// - With JTAG_MASTER_TRST_EN: OP_RESET -> trst_n_o low for 4*CLK_DIV clk, then 6 TMS TCK.

Source files
------------

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - JTAG TAP state/op types, command FSM states and TAP transition function
package tap_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_SCAN_IR = 2'd1,
    OP_SCAN_DR = 2'd2,
    OP_RUNTEST = 2'd3
  } tap_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TRST, ST_PREAMBLE, ST_NAV_IN, ST_SHIFT, ST_NAV_OUT, ST_RESP
  } mst_state_t;

  localparam int TAP_RESET_TMS_CYCLES = 5;

  function automatic tap_state_t tap_next_state(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with rise/fall strobes that always finishes a high phase before stopping
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic trst_i,
  input  logic start_i,
  output logic tck_o,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             phase_end;

  assign phase_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
  // Strobes are high in the cycle before the clk edge that moves tck_o.
  assign rise_pulse = start_i && !tck_o && phase_end;
  assign fall_pulse = tck_o && phase_end;

  // Count half-periods while enabled; a started high phase always completes, then TCK parks low.
  always_ff @(posedge clk_i or negedge trst_i) begin
    if (!trst_i) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (start_i || tck_o) begin
      if (phase_end) begin
        cnt_q <= '0;
        tck_o <= ~tck_o;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/jtag_tap_master.sv
// rtl/jtag_tap_master.sv - host-side JTAG initiator; JTAG_MASTER_TRST_EN adds a target TRST pulse to OP_RESET
module jtag_tap_master
  import tap_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               trst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               trst_n_o,
  output logic [3:0]         tap_state_o
);

  mst_state_t         state_q, state_d;
  tap_op_t            op_q, op_n;
  tap_state_t         shadow_q;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q;
  logic [MAX_LEN-1:0] tdi_sr_q, cap_q;
  logic               rsp_valid_q, rsp_err_q, tms_q, tdi_q;
  logic               accept, adv, tms_d, tdi_d, cmd_err, pre, start;
  logic               rise_pulse, fall_pulse;

  assign cmd_err = (tap_op_t'(cmd_op_i) != OP_RESET) &&
                   ((cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_LEN)));
  assign pre     = (shadow_q == TEST_LOGIC_RESET);
  assign start   = (state_q == ST_PREAMBLE) || (state_q == ST_NAV_IN) ||
                   (state_q == ST_SHIFT) || (state_q == ST_NAV_OUT);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk_i      (clk_i),
    .trst_i     (trst_i),
    .start_i    (start),
    .tck_o      (tck_o),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

`ifdef JTAG_MASTER_TRST_EN
  localparam int TRST_CLKS = 4 * CLK_DIV;
  localparam int TRST_W    = $clog2(TRST_CLKS);
  logic [TRST_W-1:0] trst_cnt_q;

  // Time two TCK periods of target TRST while TCK stays parked low.
  always_ff @(posedge clk_i or negedge trst_i) begin
    if (!trst_i)                 trst_cnt_q <= TRST_W'(TRST_CLKS - 1);
    else if (state_q != ST_TRST) trst_cnt_q <= TRST_W'(TRST_CLKS - 1);
    else                         trst_cnt_q <= trst_cnt_q - 1'b1;
  end

  assign trst_n_o = (state_q != ST_TRST);
`else
  assign trst_n_o = 1'b1;
`endif

  // Next state/bit counter, plus the TMS/TDI value of the bit that starts on this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    adv     = 1'b0;
    op_n    = (state_q == ST_IDLE) ? tap_op_t'(cmd_op_i) : op_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (cmd_err) begin
            state_d = ST_RESP;
          end else if (op_n == OP_RESET) begin
`ifdef JTAG_MASTER_TRST_EN
            state_d = ST_TRST;
`else
            state_d = ST_PREAMBLE;
            cnt_d   = LEN_W'(TAP_RESET_TMS_CYCLES);
            adv     = 1'b1;
`endif
          end else if (op_n == OP_RUNTEST || pre) begin
            state_d = ST_PREAMBLE;
            if (op_n == OP_RUNTEST) cnt_d = pre ? cmd_len_i : cmd_len_i - LEN_W'(1);
            else                    cnt_d = '0;
            adv     = 1'b1;
          end else begin
            state_d = ST_NAV_IN;
            cnt_d   = (op_n == OP_SCAN_IR) ? LEN_W'(3) : LEN_W'(2);
            adv     = 1'b1;
          end
        end
      end
`ifdef JTAG_MASTER_TRST_EN
      ST_TRST: begin
        if (trst_cnt_q == '0) begin
          state_d = ST_PREAMBLE;
          cnt_d   = LEN_W'(TAP_RESET_TMS_CYCLES);
          adv     = 1'b1;
        end
      end
`endif
      ST_PREAMBLE, ST_NAV_IN, ST_SHIFT, ST_NAV_OUT: begin
        if (fall_pulse) begin
          adv = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end else if (state_q == ST_PREAMBLE) begin
            if (op_q == OP_SCAN_IR || op_q == OP_SCAN_DR) begin
              state_d = ST_NAV_IN;
              cnt_d   = (op_q == OP_SCAN_IR) ? LEN_W'(3) : LEN_W'(2);
            end else begin
              state_d = ST_RESP;
            end
          end else if (state_q == ST_NAV_IN) begin
            state_d = ST_SHIFT;
            cnt_d   = len_q - LEN_W'(1);
          end else if (state_q == ST_SHIFT) begin
            state_d = ST_NAV_OUT;
            cnt_d   = LEN_W'(1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tms_d = tms_q;
    case (state_d)
      ST_PREAMBLE: tms_d = (op_n == OP_RESET) && (cnt_d != '0);
      ST_NAV_IN:   tms_d = (cnt_d >= LEN_W'(2));
      ST_SHIFT:    tms_d = (cnt_d == '0);
      ST_NAV_OUT:  tms_d = (cnt_d == LEN_W'(1));
      default:     tms_d = tms_q;
    endcase
    tdi_d = 1'b0;
    if (state_d == ST_SHIFT) tdi_d = (state_q == ST_SHIFT) ? tdi_sr_q[1] : tdi_sr_q[0];
  end

  // Command/bit sequencing registers, TDI/TDO shift data and the shadow TAP state.
  always_ff @(posedge clk_i or negedge trst_i) begin
    if (!trst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_RESET;
      cnt_q    <= '0;
      len_q    <= '0;
      tdi_sr_q <= '0;
      cap_q    <= '0;
      rsp_err_q <= 1'b0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      shadow_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (adv) begin
        tms_q <= tms_d;
        tdi_q <= tdi_d;
      end
      if (accept) begin
        op_q      <= op_n;
        len_q     <= cmd_len_i;
        tdi_sr_q  <= cmd_data_i;
        cap_q     <= '0;
        rsp_err_q <= cmd_err;
      end else if (fall_pulse && state_q == ST_SHIFT) begin
        tdi_sr_q <= tdi_sr_q >> 1;
      end
      if (rise_pulse) begin
        shadow_q <= tap_next_state(shadow_q, tms_q);
        if (state_q == ST_SHIFT)
          cap_q <= cap_q | (MAX_LEN'(tdo_i) << (len_q - LEN_W'(1) - cnt_q));
      end
`ifdef JTAG_MASTER_TRST_EN
      if (state_q == ST_TRST) shadow_q <= TEST_LOGIC_RESET;
`endif
    end
  end

  // Response valid rises one clk after entering RESP and drops on the handshake.
  always_ff @(posedge clk_i or negedge trst_i) begin
    if (!trst_i)                                  rsp_valid_q <= 1'b0;
    else if (state_q == ST_RESP && !rsp_valid_q)  rsp_valid_q <= 1'b1;
    else if (rsp_valid_q && rsp_ready_i)          rsp_valid_q <= 1'b0;
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = cap_q;
  assign rsp_err_o   = rsp_err_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign tap_state_o = shadow_q;

endmodule
